// File: rtl/tdm_route_mux_if.sv
// Route-mux bus bundle: packed source/destination buses, selects, mode controls and route status.
// master drives sources and controls; slave is the route block.
interface tdm_route_mux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]          src_sel;
  logic [SEL_W-1:0]          dst_sel;
  logic                      enable;
  logic                      auto_mode;
  logic [CHANNELS*WIDTH-1:0] out_bus;
  logic [SEL_W-1:0]          active_src;
  logic [SEL_W-1:0]          active_dst;
  logic                      valid;

  modport master (
    output in_bus, src_sel, dst_sel, enable, auto_mode,
    input  out_bus, active_src, active_dst, valid
  );

  modport slave (
    input  in_bus, src_sel, dst_sel, enable, auto_mode,
    output out_bus, active_src, active_dst, valid
  );
endinterface

// File: rtl/tdm_route_mux.sv
// Registered N-slot route mux (manual select or auto-scan every DWELL cycles); 1-cycle latency.
// No backpressure: every input is sampled each edge and the result is always accepted downstream.
module tdm_route_mux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int DWELL    = 50_000_000,
  parameter int LATCH    = 0,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic            clk,
  input logic            rst_n,
  tdm_route_mux_if.slave bus
);

  localparam int                 BUS_W    = CHANNELS * WIDTH;
  localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   active_src_q, active_src_d;
  logic [SEL_W-1:0]   active_dst_q, active_dst_d;
  logic               valid_q, valid_d;

  logic               do_route;
  logic [SEL_W-1:0]   route_src;
  logic [SEL_W-1:0]   route_dst;
  logic [SEL_W-1:0]   scan_idx;
  logic [CNT_W-1:0]   scan_cnt;
  logic               src_ok;
  logic               dst_ok;
  logic [WIDTH-1:0]   src_slot;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    active_src_d = active_src_q;
    active_dst_d = active_dst_q;
    valid_d      = valid_q;
    do_route     = 1'b0;
    route_src    = bus.src_sel;
    route_dst    = bus.dst_sel;
    scan_idx     = '0;
    scan_cnt     = '0;
    src_ok       = 1'b0;
    dst_ok       = 1'b0;
    src_slot     = '0;

    if (!bus.enable) begin
      state_d = IDLE;
      out_d   = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!bus.auto_mode) begin
      state_d  = MANUAL;
      idx_d    = '0;
      cnt_d    = '0;
      do_route = 1'b1;
    end else begin
      state_d = AUTO;
      // Entering AUTO from another state starts the scan at channel 0, counting this edge as its first.
      scan_idx  = (state_q == AUTO) ? idx_q : '0;
      scan_cnt  = (state_q == AUTO) ? cnt_q : '0;
      route_src = scan_idx;
      route_dst = scan_idx;
      do_route  = 1'b1;
      if (scan_cnt == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (scan_idx == IDX_LAST) ? '0 : scan_idx + SEL_W'(1);
      end else begin
        cnt_d = scan_cnt + CNT_W'(1);
        idx_d = scan_idx;
      end
    end

    if (do_route) begin
      // Loop-based decode keeps out-of-range selects (non-power-of-2 CHANNELS) from indexing the bus.
      for (int k = 0; k < CHANNELS; k++) begin
        if (route_src == SEL_W'(k)) begin
          src_ok   = 1'b1;
          src_slot = bus.in_bus[k*WIDTH +: WIDTH];
        end
        if (route_dst == SEL_W'(k)) begin
          dst_ok = 1'b1;
        end
      end

      if (LATCH == 0) begin
        out_d = '0;
      end

      if (src_ok && dst_ok) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (route_dst == SEL_W'(k)) begin
            out_d[k*WIDTH +: WIDTH] = src_slot;
          end
        end
        active_src_d = route_src;
        active_dst_d = route_dst;
        valid_d      = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      active_src_q <= '0;
      active_dst_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      active_src_q <= active_src_d;
      active_dst_q <= active_dst_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.out_bus    = out_q;
  assign bus.active_src = active_src_q;
  assign bus.active_dst = active_dst_q;
  assign bus.valid      = valid_q;

endmodule

// File: tb/tb_tdm_route_mux.sv
// Bench for tdm_route_mux: four configurations (4/3 channels x LATCH 0/1) share one stimulus stream,
// checked against fixed vectors and an age-based behavioural model.
module tb_tdm_route_mux;

  localparam int DWELL = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_bus;
  logic [1:0]  src_sel;
  logic [1:0]  dst_sel;
  logic        enable;
  logic        auto_mode;

  int total;
  int passed;

  tdm_route_mux_if #(.CHANNELS(4), .WIDTH(4)) if0 ();
  tdm_route_mux_if #(.CHANNELS(4), .WIDTH(4)) if1 ();
  tdm_route_mux_if #(.CHANNELS(3), .WIDTH(4)) if2 ();
  tdm_route_mux_if #(.CHANNELS(3), .WIDTH(4)) if3 ();

  assign if0.in_bus = in_bus;        assign if1.in_bus = in_bus;
  assign if2.in_bus = in_bus[11:0];  assign if3.in_bus = in_bus[11:0];
  assign if0.src_sel = src_sel;      assign if1.src_sel = src_sel;
  assign if2.src_sel = src_sel;      assign if3.src_sel = src_sel;
  assign if0.dst_sel = dst_sel;      assign if1.dst_sel = dst_sel;
  assign if2.dst_sel = dst_sel;      assign if3.dst_sel = dst_sel;
  assign if0.enable = enable;        assign if1.enable = enable;
  assign if2.enable = enable;        assign if3.enable = enable;
  assign if0.auto_mode = auto_mode;  assign if1.auto_mode = auto_mode;
  assign if2.auto_mode = auto_mode;  assign if3.auto_mode = auto_mode;

  tdm_route_mux #(.CHANNELS(4), .WIDTH(4), .DWELL(DWELL), .LATCH(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  tdm_route_mux #(.CHANNELS(4), .WIDTH(4), .DWELL(DWELL), .LATCH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  tdm_route_mux #(.CHANNELS(3), .WIDTH(4), .DWELL(DWELL), .LATCH(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  tdm_route_mux #(.CHANNELS(3), .WIDTH(4), .DWELL(DWELL), .LATCH(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per instance, destination slot contents plus the number of consecutive AUTO edges.
  int         m_ch  [4] = '{4, 4, 3, 3};
  bit         m_lat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] m_slot[4][4];
  bit         m_vld [4];
  int         m_as  [4];
  int         m_ad  [4];
  int         m_age [4];

  function automatic void m_reset();
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 4; k++) m_slot[n][k] = 4'h0;
      m_vld[n] = 1'b0;
      m_as[n]  = 0;
      m_ad[n]  = 0;
      m_age[n] = 0;
    end
  endfunction

  function automatic void m_step();
    for (int n = 0; n < 4; n++) begin
      int ch;
      int s;
      int d;
      int i;
      ch = m_ch[n];
      s  = int'(src_sel);
      d  = int'(dst_sel);
      if (!enable) begin
        for (int k = 0; k < 4; k++) m_slot[n][k] = 4'h0;
        m_vld[n] = 1'b0;
        m_age[n] = 0;
      end else if (!auto_mode) begin
        m_age[n] = 0;
        if (!m_lat[n]) for (int k = 0; k < 4; k++) m_slot[n][k] = 4'h0;
        if (s < ch && d < ch) begin
          m_slot[n][d] = in_bus[s*4 +: 4];
          m_vld[n] = 1'b1;
          m_as[n]  = s;
          m_ad[n]  = d;
        end else begin
          m_vld[n] = 1'b0;
        end
      end else begin
        i = (m_age[n] / DWELL) % ch;
        if (!m_lat[n]) for (int k = 0; k < 4; k++) m_slot[n][k] = 4'h0;
        m_slot[n][i] = in_bus[i*4 +: 4];
        m_vld[n] = 1'b1;
        m_as[n]  = i;
        m_ad[n]  = i;
        m_age[n] = m_age[n] + 1;
      end
    end
  endfunction

  function automatic logic [15:0] m_out(int n);
    logic [15:0] r;
    r = 16'h0;
    for (int k = 0; k < m_ch[n]; k++) r[k*4 +: 4] = m_slot[n][k];
    return r;
  endfunction

  task automatic get_dut(input int n, output logic [15:0] o, output logic v,
                         output logic [1:0] a_s, output logic [1:0] a_d);
    case (n)
      0:       begin o = if0.out_bus;         v = if0.valid; a_s = if0.active_src; a_d = if0.active_dst; end
      1:       begin o = if1.out_bus;         v = if1.valid; a_s = if1.active_src; a_d = if1.active_dst; end
      2:       begin o = {4'h0, if2.out_bus}; v = if2.valid; a_s = if2.active_src; a_d = if2.active_dst; end
      default: begin o = {4'h0, if3.out_bus}; v = if3.valid; a_s = if3.active_src; a_d = if3.active_dst; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed = passed + 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] o;
    logic        v;
    logic [1:0]  a_s;
    logic [1:0]  a_d;
    for (int n = 0; n < 4; n++) begin
      get_dut(n, o, v, a_s, a_d);
      chk($sformatf("%s u%0d out_bus", tag, n), {16'h0, o}, {16'h0, m_out(n)});
      chk($sformatf("%s u%0d valid", tag, n), {31'h0, v}, {31'h0, m_vld[n]});
      chk($sformatf("%s u%0d active_src", tag, n), {30'h0, a_s}, m_as[n]);
      chk($sformatf("%s u%0d active_dst", tag, n), {30'h0, a_d}, m_ad[n]);
    end
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [15:0] in_v;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic        en;
    logic        am;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        vld;
    logic [1:0]  as_v;
    logic [1:0]  ad_v;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] o;
    logic        v;
    logic [1:0]  a_s;
    logic [1:0]  a_d;
    int          c;

    vecs[0] = '{16'h4321, 2'd2, 2'd1, 1'b1, 1'b0, 16'h0030, 16'h0030, 1'b1, 2'd2, 2'd1};
    vecs[1] = '{16'h4F21, 2'd2, 2'd1, 1'b1, 1'b0, 16'h00F0, 16'h00F0, 1'b1, 2'd2, 2'd1};
    vecs[2] = '{16'h4F21, 2'd2, 2'd1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd2, 2'd1};
    vecs[3] = '{16'h4321, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b1, 2'd0, 2'd0};
    vecs[4] = '{16'h4321, 2'd3, 2'd2, 1'b1, 1'b0, 16'h0400, 16'h0401, 1'b1, 2'd3, 2'd2};
    vecs[5] = '{16'h4321, 2'd1, 2'd2, 1'b1, 1'b0, 16'h0200, 16'h0201, 1'b1, 2'd1, 2'd2};

    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_bus    = 16'h0;
    src_sel   = 2'd0;
    dst_sel   = 2'd0;
    enable    = 1'b0;
    auto_mode = 1'b0;
    m_reset();
    #2;
    check_all("reset");
    #5;
    rst_n = 1'b1;

    // Nothing is routed until an edge sees enable high.
    tick("post_reset_idle");

    for (int r = 0; r < 6; r++) begin
      in_bus    = vecs[r].in_v;
      src_sel   = vecs[r].src;
      dst_sel   = vecs[r].dst;
      enable    = vecs[r].en;
      auto_mode = vecs[r].am;
      tick($sformatf("vec%0d", r));
      get_dut(0, o, v, a_s, a_d);
      chk($sformatf("vec%0d L0 out_bus", r), {16'h0, o}, {16'h0, vecs[r].exp0});
      chk($sformatf("vec%0d valid", r), {31'h0, v}, {31'h0, vecs[r].vld});
      chk($sformatf("vec%0d active_src", r), {30'h0, a_s}, {30'h0, vecs[r].as_v});
      chk($sformatf("vec%0d active_dst", r), {30'h0, a_d}, {30'h0, vecs[r].ad_v});
      get_dut(1, o, v, a_s, a_d);
      chk($sformatf("vec%0d L1 out_bus", r), {16'h0, o}, {16'h0, vecs[r].exp1});
    end

    // Auto-scan: each channel held DWELL edges, 4-ch wraps 3->0, 3-ch wraps 2->0.
    in_bus    = 16'h4321;
    enable    = 1'b1;
    auto_mode = 1'b1;
    for (int e = 0; e < 22; e++) begin
      tick($sformatf("scan%0d", e));
      c = (e / DWELL) % 4;
      get_dut(0, o, v, a_s, a_d);
      chk($sformatf("scan%0d u0 out_bus", e), {16'h0, o}, 32'(c + 1) << (4 * c));
      if (e == 8) begin
        get_dut(2, o, v, a_s, a_d);
        chk("scan8 u2 out_bus", {16'h0, o}, 32'h0300);
      end
      if (e == 12) begin
        get_dut(2, o, v, a_s, a_d);
        chk("scan12 u2 wrap out_bus", {16'h0, o}, 32'h0001);
      end
    end
    auto_mode = 1'b0;
    src_sel   = 2'd1;
    dst_sel   = 2'd3;
    tick("scan_drop");
    get_dut(0, o, v, a_s, a_d);
    chk("scan_drop u0 out_bus", {16'h0, o}, 32'h2000);
    auto_mode = 1'b1;
    tick("scan_reenter");
    get_dut(0, o, v, a_s, a_d);
    chk("scan_reenter u0 out_bus", {16'h0, o}, 32'h0001);

    // Three-channel illegal selects.
    enable = 1'b0;
    tick("ch3_clear");
    enable    = 1'b1;
    auto_mode = 1'b0;
    src_sel   = 2'd2;
    dst_sel   = 2'd2;
    tick("ch3_legal");
    get_dut(3, o, v, a_s, a_d);
    chk("ch3_legal u3 out_bus", {16'h0, o}, 32'h0300);
    src_sel = 2'd3;
    dst_sel = 2'd0;
    tick("ch3_bad_src");
    get_dut(2, o, v, a_s, a_d);
    chk("ch3_bad_src u2 out_bus", {16'h0, o}, 32'h0000);
    chk("ch3_bad_src u2 valid", {31'h0, v}, 32'h0);
    get_dut(3, o, v, a_s, a_d);
    chk("ch3_bad_src u3 out_bus", {16'h0, o}, 32'h0300);
    chk("ch3_bad_src u3 valid", {31'h0, v}, 32'h0);
    src_sel = 2'd1;
    dst_sel = 2'd0;
    tick("ch3_legal2");
    get_dut(3, o, v, a_s, a_d);
    chk("ch3_legal2 u3 out_bus", {16'h0, o}, 32'h0302);
    src_sel = 2'd0;
    dst_sel = 2'd3;
    tick("ch3_bad_dst");
    get_dut(3, o, v, a_s, a_d);
    chk("ch3_bad_dst u3 out_bus", {16'h0, o}, 32'h0302);
    chk("ch3_bad_dst u3 valid", {31'h0, v}, 32'h0);

    // Asynchronous reset in the middle of a scan, between clock edges.
    auto_mode = 1'b1;
    for (int e = 0; e < 6; e++) tick($sformatf("prerst%0d", e));
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("async_rst");
    #1;
    rst_n  = 1'b1;
    enable = 1'b0;
    tick("rst_idle");
    enable = 1'b1;
    tick("rst_reenter");
    get_dut(0, o, v, a_s, a_d);
    chk("rst_reenter u0 out_bus", {16'h0, o}, 32'h0001);

    for (int e = 0; e < 600; e++) begin
      in_bus  = 16'($urandom);
      src_sel = 2'($urandom);
      dst_sel = 2'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        enable    = ($urandom_range(0, 4) != 0);
        auto_mode = 1'($urandom);
      end
      tick($sformatf("rand%0d", e));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
